// File: rtl/sram_1rw_arbiter.sv
// Round-robin arbiter sharing one single-port 1rw SRAM macro between two val/rdy requesters.
// Each port owns a one-entry response buffer that is filled the cycle after its request issues.
module sram_1rw_arbiter #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 256,
    localparam int c_addr_nbits = $clog2(p_num_entries),
    localparam int c_mask_nbits = p_data_nbits / 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic                    req0_wen,
    input  logic [c_addr_nbits-1:0] req0_addr,
    input  logic [c_mask_nbits-1:0] req0_wmask,
    input  logic [p_data_nbits-1:0] req0_data,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic                    req1_wen,
    input  logic [c_addr_nbits-1:0] req1_addr,
    input  logic [c_mask_nbits-1:0] req1_wmask,
    input  logic [p_data_nbits-1:0] req1_data,

    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [p_data_nbits-1:0] resp0_data,

    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_data_nbits-1:0] resp1_data,

    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [c_mask_nbits-1:0] sram_wmask,
    output logic [c_addr_nbits-1:0] sram_addr,
    output logic [p_data_nbits-1:0] sram_din,
    input  logic [p_data_nbits-1:0] sram_dout
);

    logic                    prio;
    logic                    inflight_val;
    logic                    inflight_port;
    logic                    inflight_wen;
    logic [1:0]              rbuf_val;
    logic [p_data_nbits-1:0] rbuf_data [2];

    logic [1:0]              req_val;
    logic [1:0]              req_wen;
    logic [c_addr_nbits-1:0] req_addr  [2];
    logic [c_mask_nbits-1:0] req_wmask [2];
    logic [p_data_nbits-1:0] req_data  [2];
    logic [1:0]              resp_rdy;
    logic [1:0]              resp_fire;
    logic [1:0]              elig;
    logic [1:0]              grant;
    logic                    grant_any;
    logic                    grant_port;

    logic                    sel_wen;
    logic [c_addr_nbits-1:0] sel_addr;
    logic [c_mask_nbits-1:0] sel_wmask;
    logic [p_data_nbits-1:0] sel_data;

    assign req_val      = {req1_val, req0_val};
    assign req_wen      = {req1_wen, req0_wen};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wmask[0] = req0_wmask;
    assign req_wmask[1] = req1_wmask;
    assign req_data[0]  = req0_data;
    assign req_data[1]  = req1_data;
    assign resp_rdy     = {resp1_rdy, resp0_rdy};
    assign resp_fire    = rbuf_val & resp_rdy;

    // A port may issue only if its buffer will be free when the read data lands
    // and it has no request already in flight (which would refill that buffer).
    always_comb begin
        elig = '0;
        for (int n = 0; n < 2; n++) begin
            elig[n] = !reset && req_val[n]
                      && (!rbuf_val[n] || resp_fire[n])
                      && !(inflight_val && (inflight_port == 1'(n)));
        end
    end

    always_comb begin
        grant_any  = |elig;
        grant_port = (&elig) ? prio : elig[1];
        grant      = '0;
        grant[0]   = grant_any && !grant_port;
        grant[1]   = grant_any && grant_port;
    end

    always_comb begin
        sel_wen   = req_wen[grant_port];
        sel_addr  = req_addr[grant_port];
        sel_wmask = req_wmask[grant_port];
        sel_data  = req_data[grant_port];
    end

    assign req0_rdy   = grant[0];
    assign req1_rdy   = grant[1];

    assign sram_csb   = !grant_any;
    assign sram_web   = !(grant_any && sel_wen);
    assign sram_addr  = grant_any ? sel_addr : '0;
    assign sram_wmask = (grant_any && sel_wen) ? sel_wmask : '0;
    assign sram_din   = grant_any ? sel_data : '0;

    assign resp0_val  = rbuf_val[0] && !reset;
    assign resp1_val  = rbuf_val[1] && !reset;
    assign resp0_data = rbuf_data[0];
    assign resp1_data = rbuf_data[1];

    // Write acks carry zero data so every accepted request yields exactly one response.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio          <= 1'b0;
            inflight_val  <= 1'b0;
            inflight_port <= 1'b0;
            inflight_wen  <= 1'b0;
            rbuf_val      <= '0;
            rbuf_data[0]  <= '0;
            rbuf_data[1]  <= '0;
        end else begin
            if (grant_any) begin
                prio <= !grant_port;
            end
            inflight_val  <= grant_any;
            inflight_port <= grant_port;
            inflight_wen  <= grant_any && sel_wen;
            for (int n = 0; n < 2; n++) begin
                if (inflight_val && (inflight_port == 1'(n))) begin
                    rbuf_val[n]  <= 1'b1;
                    rbuf_data[n] <= inflight_wen ? '0 : sram_dout;
                end else if (resp_fire[n]) begin
                    rbuf_val[n]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter: per-cycle vector table plus streamed back-pressure
// and mid-flight reset sequences, with a behavioural 1rw SRAM macro model.
module tb_sram_1rw_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_val, req0_rdy, req0_wen;
    logic [7:0]  req0_addr;
    logic [3:0]  req0_wmask;
    logic [31:0] req0_data;
    logic        req1_val, req1_rdy, req1_wen;
    logic [7:0]  req1_addr;
    logic [3:0]  req1_wmask;
    logic [31:0] req1_data;
    logic        resp0_val, resp0_rdy;
    logic [31:0] resp0_data;
    logic        resp1_val, resp1_rdy;
    logic [31:0] resp1_data;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int checks = 0;
    int errors = 0;

    sram_1rw_arbiter #(.p_data_nbits(32), .p_num_entries(256)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_wen(req0_wen),
        .req0_addr(req0_addr), .req0_wmask(req0_wmask), .req0_data(req0_data),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_wen(req1_wen),
        .req1_addr(req1_addr), .req1_wmask(req1_wmask), .req1_data(req1_data),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_data(resp0_data),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_data(resp1_data),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: registered read, byte-masked write, garbage on dout after writes.
    logic [31:0] mem [256];
    logic        init_mem;

    function automatic logic [31:0] init_val(int i);
        case (i)
            16:      return 32'hDEADBEEF;
            5:       return 32'hAAAAAAAA;
            127:     return 32'hCAFEF00D;
            default: return 32'h1000_0000 + 32'(i);
        endcase
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                sram_dout <= 32'hBAD0BAD0;
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        string            name;
        logic             rst;
        logic [1:0]       val;
        logic [1:0]       wen;
        logic [1:0]       rr;
        logic [1:0][7:0]  addr;
        logic [1:0][3:0]  mask;
        logic [1:0][31:0] data;
        logic [1:0]       x_rdy;
        logic             x_csb;
        logic             x_web;
        logic [7:0]       x_addr;
        logic [3:0]       x_mask;
        logic [31:0]      x_din;
        logic [1:0]       x_rv;
        logic [1:0][31:0] x_rd;
    } vec_t;

    function automatic vec_t nv(string n);
        vec_t v;
        v.name = n;   v.rst = 1'b0;  v.val = '0;     v.wen = '0;   v.rr = 2'b11;
        v.addr = '0;  v.mask = '0;   v.data = '0;    v.x_rdy = '0;
        v.x_csb = 1'b1; v.x_web = 1'b1; v.x_addr = '0; v.x_mask = '0; v.x_din = '0;
        v.x_rv = '0;  v.x_rd = '0;
        return v;
    endfunction

    function automatic vec_t rstv(string n);
        vec_t v = nv(n);
        v.rst = 1'b1;
        v.val = 2'b11;
        v.addr[1] = 8'h40;
        return v;
    endfunction

    function automatic vec_t rd(vec_t v, int p, logic [7:0] a);
        v.val[p] = 1'b1; v.wen[p] = 1'b0; v.addr[p] = a;
        return v;
    endfunction

    function automatic vec_t wr(vec_t v, int p, logic [7:0] a, logic [3:0] m, logic [31:0] d);
        v.val[p] = 1'b1; v.wen[p] = 1'b1; v.addr[p] = a; v.mask[p] = m; v.data[p] = d;
        return v;
    endfunction

    function automatic vec_t gnt(vec_t v, int p, logic w, logic [7:0] a, logic [3:0] m, logic [31:0] d);
        v.x_rdy[p] = 1'b1; v.x_csb = 1'b0; v.x_web = !w; v.x_addr = a;
        v.x_mask = w ? m : 4'h0; v.x_din = d;
        return v;
    endfunction

    function automatic vec_t rsp(vec_t v, int p, logic [31:0] d);
        v.x_rv[p] = 1'b1; v.x_rd[p] = d;
        return v;
    endfunction

    task automatic check_field(string name, string what, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, what, act, exp);
        end
    endtask

    task automatic check_output(vec_t v);
        check_field(v.name, "req0_rdy", 32'(req0_rdy), 32'(v.x_rdy[0]));
        check_field(v.name, "req1_rdy", 32'(req1_rdy), 32'(v.x_rdy[1]));
        check_field(v.name, "sram_csb", 32'(sram_csb), 32'(v.x_csb));
        check_field(v.name, "sram_web", 32'(sram_web), 32'(v.x_web));
        check_field(v.name, "sram_addr", 32'(sram_addr), 32'(v.x_addr));
        check_field(v.name, "sram_wmask", 32'(sram_wmask), 32'(v.x_mask));
        if (!v.x_web) check_field(v.name, "sram_din", sram_din, v.x_din);
        check_field(v.name, "resp0_val", 32'(resp0_val), 32'(v.x_rv[0]));
        check_field(v.name, "resp1_val", 32'(resp1_val), 32'(v.x_rv[1]));
        if (v.x_rv[0]) check_field(v.name, "resp0_data", resp0_data, v.x_rd[0]);
        if (v.x_rv[1]) check_field(v.name, "resp1_data", resp1_data, v.x_rd[1]);
    endtask

    task automatic apply_stimulus(vec_t v);
        @(negedge clk);
        reset      = v.rst;
        req0_val   = v.val[0];  req0_wen = v.wen[0];  req0_addr = v.addr[0];
        req0_wmask = v.mask[0]; req0_data = v.data[0];
        req1_val   = v.val[1];  req1_wen = v.wen[1];  req1_addr = v.addr[1];
        req1_wmask = v.mask[1]; req1_data = v.data[1];
        resp0_rdy  = v.rr[0];   resp1_rdy = v.rr[1];
        #1;
        check_output(v);
    endtask

    vec_t tbl[$];
    vec_t rst_seq[$];

    task automatic build_table();
        tbl.push_back(rstv("rst_a"));
        tbl.push_back(rstv("rst_b"));
        tbl.push_back(gnt(rd(nv("t1_issue"), 0, 8'h10), 0, 0, 8'h10, 4'h0, 32'h0));
        tbl.push_back(nv("t1_wait"));
        tbl.push_back(rsp(nv("t1_resp"), 0, 32'hDEADBEEF));
        tbl.push_back(nv("t1_idle"));
        tbl.push_back(gnt(wr(nv("t2_write"), 1, 8'h05, 4'b0101, 32'h11223344),
                          1, 1, 8'h05, 4'b0101, 32'h11223344));
        tbl.push_back(nv("t2_wait"));
        tbl.push_back(rsp(gnt(rd(nv("t2_ack_rd"), 1, 8'h05), 1, 0, 8'h05, 4'h0, 32'h0), 1, 32'h0));
        tbl.push_back(nv("t2_wait2"));
        tbl.push_back(rsp(nv("t2_rdata"), 1, 32'hAA22AA44));
        tbl.push_back(nv("t2_idle"));
        tbl.push_back(rstv("t3_rst"));
        tbl.push_back(gnt(rd(rd(nv("t3_c0"), 0, 8'h30), 1, 8'h40), 0, 0, 8'h30, 4'h0, 32'h0));
        tbl.push_back(gnt(rd(rd(nv("t3_c1"), 0, 8'h31), 1, 8'h40), 1, 0, 8'h40, 4'h0, 32'h0));
        tbl.push_back(rsp(gnt(rd(rd(nv("t3_c2"), 0, 8'h31), 1, 8'h41), 0, 0, 8'h31, 4'h0, 32'h0),
                          0, 32'h10000030));
        tbl.push_back(rsp(gnt(rd(rd(nv("t3_c3"), 0, 8'h32), 1, 8'h41), 1, 0, 8'h41, 4'h0, 32'h0),
                          1, 32'h10000040));
        tbl.push_back(rsp(gnt(rd(rd(nv("t3_c4"), 0, 8'h32), 1, 8'h42), 0, 0, 8'h32, 4'h0, 32'h0),
                          0, 32'h10000031));
        tbl.push_back(rsp(gnt(rd(nv("t3_c5"), 1, 8'h42), 1, 0, 8'h42, 4'h0, 32'h0), 1, 32'h10000041));
        tbl.push_back(rsp(nv("t3_c6"), 0, 32'h10000032));
        tbl.push_back(rsp(nv("t3_c7"), 1, 32'h10000042));
        tbl.push_back(nv("t3_idle"));
        tbl.push_back(gnt(rd(wr(nv("hz0_both"), 0, 8'h7F, 4'hF, 32'h12345678), 1, 8'h7F),
                          0, 1, 8'h7F, 4'hF, 32'h12345678));
        tbl.push_back(gnt(rd(nv("hz0_rd"), 1, 8'h7F), 1, 0, 8'h7F, 4'h0, 32'h0));
        tbl.push_back(rsp(nv("hz0_ack"), 0, 32'h0));
        tbl.push_back(rsp(nv("hz0_rdata"), 1, 32'h12345678));
        tbl.push_back(gnt(rd(nv("hz1_setprio"), 0, 8'h10), 0, 0, 8'h10, 4'h0, 32'h0));
        tbl.push_back(nv("hz1_wait"));
        tbl.push_back(rsp(gnt(rd(wr(nv("hz1_both"), 0, 8'h7F, 4'hF, 32'h9ABCDEF0), 1, 8'h7F),
                              1, 0, 8'h7F, 4'h0, 32'h0), 0, 32'hDEADBEEF));
        tbl.push_back(gnt(wr(nv("hz1_wr"), 0, 8'h7F, 4'hF, 32'h9ABCDEF0),
                          0, 1, 8'h7F, 4'hF, 32'h9ABCDEF0));
        tbl.push_back(rsp(nv("hz1_rdata"), 1, 32'h12345678));
        tbl.push_back(rsp(nv("hz1_ack"), 0, 32'h0));
        tbl.push_back(gnt(rd(nv("hz1_verify"), 0, 8'h7F), 0, 0, 8'h7F, 4'h0, 32'h0));
        tbl.push_back(nv("hz1_wait2"));
        tbl.push_back(rsp(nv("hz1_newval"), 0, 32'h9ABCDEF0));
        tbl.push_back(nv("hz1_idle"));
    endtask

    task automatic build_rst_seq();
        vec_t v;
        rst_seq.push_back(gnt(rd(nv("rm_issue"), 0, 8'h10), 0, 0, 8'h10, 4'h0, 32'h0));
        v = rstv("rm_rst0"); v.addr[0] = 8'h10; rst_seq.push_back(v);
        v = rstv("rm_rst1"); v.addr[0] = 8'h10; rst_seq.push_back(v);
        rst_seq.push_back(nv("rm_post0"));
        rst_seq.push_back(nv("rm_post1"));
        rst_seq.push_back(gnt(rd(rd(nv("rm_cont"), 0, 8'h30), 1, 8'h40), 0, 0, 8'h30, 4'h0, 32'h0));
        rst_seq.push_back(gnt(rd(nv("rm_p1"), 1, 8'h40), 1, 0, 8'h40, 4'h0, 32'h0));
        rst_seq.push_back(rsp(nv("rm_r0"), 0, 32'h10000030));
        rst_seq.push_back(rsp(nv("rm_r1"), 1, 32'h10000040));
        rst_seq.push_back(nv("rm_idle"));
    endtask

    int          acc [2];
    int          got [2];
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];

    // Streaming reads: port0 walks 0x50.., port1 walks 0x60.., responses checked in order.
    task automatic stream_cycle(int lim0, int lim1, logic rr0, logic rr1);
        @(negedge clk);
        reset     = 1'b0;
        req0_val  = (acc[0] < lim0); req0_wen = 1'b0; req0_addr = 8'(8'h50 + acc[0]);
        req1_val  = (acc[1] < lim1); req1_wen = 1'b0; req1_addr = 8'(8'h60 + acc[1]);
        resp0_rdy = rr0;
        resp1_rdy = rr1;
        #1;
        if (req0_val && req0_rdy) begin exp0.push_back(32'h10000050 + 32'(acc[0])); acc[0]++; end
        if (req1_val && req1_rdy) begin exp1.push_back(32'h10000060 + 32'(acc[1])); acc[1]++; end
        if (resp0_val && resp0_rdy) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL bp.resp0_extra actual=%h expected=none", resp0_data);
            end else check_field("bp", "resp0_data", resp0_data, exp0.pop_front());
            got[0]++;
        end
        if (resp1_val && resp1_rdy) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL bp.resp1_extra actual=%h expected=none", resp1_data);
            end else check_field("bp", "resp1_data", resp1_data, exp1.pop_front());
            got[1]++;
        end
    endtask

    initial begin
        init_mem = 1'b1;
        reset = 1'b1;
        req0_val = 1'b0; req0_wen = 1'b0; req0_addr = '0; req0_wmask = '0; req0_data = '0;
        req1_val = 1'b0; req1_wen = 1'b0; req1_addr = '0; req1_wmask = '0; req1_data = '0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 init_mem = 1'b0;

        build_table();
        for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

        $display("[TB] back-pressure on port0");
        acc[0] = 0; acc[1] = 0; got[0] = 0; got[1] = 0;
        for (int c = 0; c < 10; c++) stream_cycle(100, 100, 1'b0, 1'b1);
        check_field("bp_stall", "req0_accepts", 32'(acc[0]), 32'd1);
        check_field("bp_stall", "req1_accepts", 32'(acc[1]), 32'd5);
        check_field("bp_stall", "resp0_val", 32'(resp0_val), 32'd1);
        check_field("bp_stall", "resp0_held", resp0_data, 32'h10000050);
        for (int c = 0; c < 30; c++) stream_cycle(4, 10, 1'b1, 1'b1);
        check_field("bp_drain", "req0_accepts", 32'(acc[0]), 32'd4);
        check_field("bp_drain", "req1_accepts", 32'(acc[1]), 32'd10);
        check_field("bp_drain", "resp0_count", 32'(got[0]), 32'd4);
        check_field("bp_drain", "resp1_count", 32'(got[1]), 32'd10);
        check_field("bp_drain", "resp_missing", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("[TB] reset mid-flight");
        build_rst_seq();
        for (int i = 0; i < rst_seq.size(); i++) apply_stimulus(rst_seq[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
